// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side packer and its FIFO instantiation.
//   FIFO_IN_W / FIFO_LANES : default beat width and beats per packed word.
//   FIFO_OUT_W             : packed word width; the downstream sfifo WIDTH must equal it.
//   FIFO_CNT_W             : default width of the push counter.
//   pack_state_t, ST_*     : packer FSM encoding (single-buffer build).
package fifo_pkg;

    localparam int unsigned FIFO_IN_W  = 8;
    localparam int unsigned FIFO_LANES = 4;
    localparam int unsigned FIFO_OUT_W = FIFO_IN_W * FIFO_LANES;
    localparam int unsigned FIFO_CNT_W = 16;

    typedef logic [0:0] pack_state_t;

    localparam pack_state_t ST_FILL = 1'b0;
    localparam pack_state_t ST_PUSH = 1'b1;

endpackage

// File: rtl/fifo_wr_packer_if.sv
// Handshake bundle between a beat source, the packer and the FIFO write port.
//   s_valid/s_ready/s_data/s_last : narrow valid/ready beat stream into the packer.
//   winc/wdata/wfull              : FIFO write strobe, packed word and full flag.
// Modports:
//   master : the surroundings (beat source and FIFO) - drive beats and wfull.
//   slave  : the packer - drives s_ready, winc and wdata.
interface fifo_wr_packer_if
    import fifo_pkg::*;
#(
    parameter int unsigned IN_W  = FIFO_IN_W,
    parameter int unsigned LANES = FIFO_LANES
);

    localparam int unsigned OUT_W = IN_W * LANES;

    logic             s_valid;
    logic             s_ready;
    logic [IN_W-1:0]  s_data;
    logic             s_last;
    logic             winc;
    logic [OUT_W-1:0] wdata;
    logic             wfull;

    modport master (
        output s_valid, s_data, s_last, wfull,
        input  s_ready, winc, wdata
    );

    modport slave (
        input  s_valid, s_data, s_last, wfull,
        output s_ready, winc, wdata
    );

endinterface

// File: rtl/fifo_wr_packer_pack_lane_reg.sv
// pack_lane_reg: one OUT_W-bit packing word with a full flag.
//   wclk, rst_n      : clock, asynchronous active-low reset (word and flag to 0).
//   clr              : zero the word and drop the full flag.
//   ld_en, ld_data   : load a whole word (takes priority over clr).
//   wr_en, wr_idx,   : write one IN_W lane; applied on top of clr/ld so a cleared
//   wr_data            word can receive its first lane in the same cycle.
//   set_full         : raise the full flag (wins over clr).
//   word, full       : current contents and flag.
module pack_lane_reg #(
    parameter  int unsigned IN_W  = 8,
    parameter  int unsigned LANES = 4,
    localparam int unsigned OUT_W = IN_W * LANES,
    localparam int unsigned IDX_W = $clog2(LANES)
) (
    input  logic             wclk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             ld_en,
    input  logic [OUT_W-1:0] ld_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [IN_W-1:0]  wr_data,
    input  logic             set_full,
    output logic [OUT_W-1:0] word,
    output logic             full
);

    logic [OUT_W-1:0] word_q, word_d;
    logic             full_q, full_d;

    always_comb begin
        word_d = word_q;
        if (ld_en) begin
            word_d = ld_data;
        end else if (clr) begin
            word_d = '0;
        end
        for (int k = 0; k < LANES; k++) begin
            if (wr_en && (wr_idx == IDX_W'(k))) begin
                word_d[k*IN_W +: IN_W] = wr_data;
            end
        end
    end

    assign full_d = set_full | (full_q & ~clr);

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            full_q <= 1'b0;
        end else begin
            word_q <= word_d;
            full_q <= full_d;
        end
    end

    assign word = word_q;
    assign full = full_q;

endmodule

// File: rtl/fifo_wr_packer.sv
// fifo_wr_packer: gathers LANES narrow beats into one wide word and pushes it into
// the synchronous FIFO write port. Lane 0 (LSB) holds the first beat; s_last closes
// a partial word whose unused upper lanes stay zero.
// Ports:
//   wclk, rst_n : FIFO write clock, asynchronous active-low reset.
//   bus (slave) : s_valid/s_ready/s_data/s_last beat stream in, winc/wdata out,
//                 wfull in.
//   push_cnt    : words pushed so far, wraps modulo 2^CNT_W.
//   busy        : some beat or completed word is held and not yet pushed.
// Build option FIFO_WR_PACKER_PINGPONG_EN: adds a second (push) buffer so filling
// and draining overlap, sustaining one beat per cycle while wfull is low.
// Without it a single hold register alternates between FILL and PUSH.
module fifo_wr_packer
    import fifo_pkg::*;
#(
    parameter  int unsigned IN_W  = FIFO_IN_W,
    parameter  int unsigned LANES = FIFO_LANES,
    parameter  int unsigned CNT_W = FIFO_CNT_W,
    localparam int unsigned OUT_W = IN_W * LANES,
    localparam int unsigned IDX_W = $clog2(LANES)
) (
    input  logic              wclk,
    input  logic              rst_n,
    fifo_wr_packer_if.slave   bus,
    output logic [CNT_W-1:0]  push_cnt,
    output logic              busy
);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] push_cnt_q;
    logic             accept;
    logic             complete;

    assign accept   = bus.s_valid && bus.s_ready;
    // The accepted beat closes the word: last lane reached or packet ends.
    assign complete = accept && ((idx_q == IDX_W'(LANES - 1)) || bus.s_last);

    // Lane pointer returns to 0 explicitly when a word closes, never by wrapping.
    always_comb begin
        idx_d = idx_q;
        if (complete) begin
            idx_d = '0;
        end else if (accept) begin
            idx_d = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            push_cnt_q <= '0;
        end else begin
            idx_q <= idx_d;
            if (bus.winc) begin
                push_cnt_q <= push_cnt_q + CNT_W'(1);
            end
        end
    end

    assign push_cnt = push_cnt_q;

`ifdef FIFO_WR_PACKER_PINGPONG_EN

    logic [OUT_W-1:0] fill_word, push_word, merged_word;
    logic             fill_full, push_full;
    logic             drain, push_free, move_fill, direct;

    assign drain     = push_full && !bus.wfull;
    // Push buffer can take a word this cycle: empty, or emptying on this edge.
    assign push_free = !push_full || drain;
    // A parked complete fill word moves across as soon as the push buffer frees.
    assign move_fill = fill_full && push_free;
    // A word completing with the push buffer free bypasses the fill buffer.
    assign direct    = complete && !fill_full && push_free;

    assign bus.s_ready = !fill_full || push_free;
    assign bus.winc    = drain;
    assign bus.wdata   = push_word;

    // Fill word with the incoming beat merged into the current lane.
    always_comb begin
        merged_word = fill_word;
        for (int k = 0; k < LANES; k++) begin
            if (idx_q == IDX_W'(k)) begin
                merged_word[k*IN_W +: IN_W] = bus.s_data;
            end
        end
    end

    pack_lane_reg #(
        .IN_W  (IN_W),
        .LANES (LANES)
    ) u_fill_reg (
        .wclk     (wclk),
        .rst_n    (rst_n),
        .clr      (move_fill || direct),
        .ld_en    (1'b0),
        .ld_data  ('0),
        .wr_en    (accept && !direct),
        .wr_idx   (idx_q),
        .wr_data  (bus.s_data),
        .set_full (complete && !direct),
        .word     (fill_word),
        .full     (fill_full)
    );

    pack_lane_reg #(
        .IN_W  (IN_W),
        .LANES (LANES)
    ) u_push_reg (
        .wclk     (wclk),
        .rst_n    (rst_n),
        .clr      (drain),
        .ld_en    (move_fill || direct),
        .ld_data  (move_fill ? fill_word : merged_word),
        .wr_en    (1'b0),
        .wr_idx   ('0),
        .wr_data  ('0),
        .set_full (move_fill || direct),
        .word     (push_word),
        .full     (push_full)
    );

    assign busy = (idx_q != '0) || fill_full || push_full;

`else

    pack_state_t      state_q, state_d;
    logic [OUT_W-1:0] hold_word;
    logic             hold_full;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: if (complete) state_d = ST_PUSH;
            ST_PUSH: if (bus.winc) state_d = ST_FILL;
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.s_ready = (state_q == ST_FILL);
    assign bus.winc    = (state_q == ST_PUSH) && !bus.wfull;
    assign bus.wdata   = hold_word;

    // Clearing on every push guarantees zero padding for the next partial word.
    pack_lane_reg #(
        .IN_W  (IN_W),
        .LANES (LANES)
    ) u_hold_reg (
        .wclk     (wclk),
        .rst_n    (rst_n),
        .clr      (bus.winc),
        .ld_en    (1'b0),
        .ld_data  ('0),
        .wr_en    (accept),
        .wr_idx   (idx_q),
        .wr_data  (bus.s_data),
        .set_full (complete),
        .word     (hold_word),
        .full     (hold_full)
    );

    // hold_full rises with the closing beat and falls with the push, so it
    // tracks state == ST_PUSH exactly.
    assign busy = (idx_q != '0) || hold_full;

`endif

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Self-checking bench for fifo_wr_packer. A queue-based model of held beats and
// completed words predicts winc, wdata, s_ready, busy and push_cnt every cycle;
// directed sequences pin the model with literal expectations.
module tb_fifo_wr_packer;
    import fifo_pkg::*;

    localparam int unsigned IN_W  = 8;
    localparam int unsigned LANES = 4;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned OUT_W = IN_W * LANES;

`ifdef FIFO_WR_PACKER_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic             wclk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CNT_W-1:0] push_cnt;
    logic             busy;

    always #5 wclk = ~wclk;

    fifo_wr_packer_if #(.IN_W(IN_W), .LANES(LANES)) bus ();

    fifo_wr_packer #(
        .IN_W  (IN_W),
        .LANES (LANES),
        .CNT_W (CNT_W)
    ) dut (
        .wclk     (wclk),
        .rst_n    (rst_n),
        .bus      (bus),
        .push_cnt (push_cnt),
        .busy     (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc_last = 0;
    int unsigned model_cnt = 0;
    logic [IN_W-1:0]  part[$];
    logic [OUT_W-1:0] words[$];
    logic [OUT_W-1:0] seen_w[$];
    int               seen_cyc[$];
    logic [OUT_W-1:0] w;
    logic             exp_winc, exp_ready, exp_busy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model compare: check outputs, then apply the events of the coming edge.
    always @(negedge wclk) begin
        cyc++;
        if (!rst_n) begin
            part.delete();
            words.delete();
            model_cnt = 0;
            chk("rst_winc", 64'(bus.winc), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
            chk("rst_push_cnt", 64'(push_cnt), 64'(0));
        end else begin
            exp_winc  = (words.size() > 0) && !bus.wfull;
            exp_busy  = (part.size() > 0) || (words.size() > 0);
            exp_ready = PP ? !((words.size() >= 2) && bus.wfull) : (words.size() == 0);
            chk("winc", 64'(bus.winc), 64'(exp_winc));
            if (bus.winc && words.size() > 0) chk("wdata", 64'(bus.wdata), 64'(words[0]));
            chk("push_cnt", 64'(push_cnt), 64'(model_cnt[CNT_W-1:0]));
            chk("busy", 64'(busy), 64'(exp_busy));
            chk("s_ready", 64'(bus.s_ready), 64'(exp_ready));
            if (bus.winc) begin
                seen_w.push_back(bus.wdata);
                seen_cyc.push_back(cyc);
                if (words.size() > 0) void'(words.pop_front());
                model_cnt++;
            end
            if (bus.s_valid && bus.s_ready) begin
                acc_cyc_last = cyc;
                part.push_back(bus.s_data);
                if (part.size() == LANES || bus.s_last) begin
                    w = '0;
                    foreach (part[i]) w[i*IN_W +: IN_W] = part[i];
                    words.push_back(w);
                    part.delete();
                end
            end
        end
    end

    task automatic send(input logic [IN_W-1:0] d, input logic last);
        logic taken;
        int   n;
        taken = 1'b0;
        n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        while (!taken && n < 200) begin
            @(negedge wclk);
            taken = bus.s_ready;
            @(posedge wclk);
            #1;
            n++;
        end
        bus.s_valid = 1'b0;
        if (!taken) chk("send_accept", 64'(taken), 64'(1));
    endtask

    task automatic wait_pushes(input int n);
        int k;
        k = 0;
        while (seen_w.size() < n && k < 500) begin
            @(posedge wclk);
            #1;
            k++;
        end
        if (seen_w.size() < n) chk("push_timeout", 64'(seen_w.size()), 64'(n));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge wclk);
            #1;
        end
    endtask

    int  base, s0, nb;
    bit  rnd_done;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.wfull   = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(1);

        // Full word, one push the cycle after the fourth accept.
        base = seen_w.size();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        wait_pushes(base + 1);
        chk("t1_word", 64'(seen_w[base]), 64'(32'h44332211));
        chk("t1_latency", 64'(seen_cyc[base] - acc_cyc_last), 64'(1));
        chk("t1_cnt", 64'(push_cnt), 64'(1));

        // Partial flush, then a full word starting again at lane 0.
        base = seen_w.size();
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        wait_pushes(base + 2);
        chk("t2_partial", 64'(seen_w[base]), 64'(32'h0000BBAA));
        chk("t2_next", 64'(seen_w[base+1]), 64'(32'h04030201));
        chk("t2_cnt", 64'(push_cnt), 64'(3));

        // Backpressure: word held for five cycles of wfull.
        base = seen_w.size();
        bus.wfull = 1'b1;
        send(8'h5A, 1'b0);
        send(8'h5B, 1'b0);
        send(8'h5C, 1'b0);
        send(8'h5D, 1'b0);
        repeat (5) begin
            @(negedge wclk);
            chk("t3_winc_held", 64'(bus.winc), 64'(0));
            chk("t3_wdata_held", 64'(bus.wdata), 64'(32'h5D5C5B5A));
            if (!PP) chk("t3_ready_held", 64'(bus.s_ready), 64'(0));
            @(posedge wclk);
            #1;
        end
        bus.wfull = 1'b0;
        wait_pushes(base + 1);
        step(3);
        chk("t3_single_push", 64'(seen_w.size()), 64'(base + 1));
        chk("t3_word", 64'(seen_w[base]), 64'(32'h5D5C5B5A));
        chk("t3_cnt", 64'(push_cnt), 64'(4));

        // Reset mid-word discards the held beats.
        base = seen_w.size();
        send(8'hE1, 1'b0);
        send(8'hE2, 1'b0);
        send(8'hE3, 1'b0);
        rst_n = 1'b0;
        @(negedge wclk);
        chk("t4_busy", 64'(busy), 64'(0));
        chk("t4_cnt", 64'(push_cnt), 64'(0));
        @(posedge wclk);
        #1;
        rst_n = 1'b1;
        step(1);
        chk("t4_no_push", 64'(seen_w.size()), 64'(base));
        send(8'h71, 1'b0);
        send(8'h72, 1'b0);
        send(8'h73, 1'b0);
        send(8'h74, 1'b0);
        wait_pushes(base + 1);
        step(2);
        chk("t4_one_push", 64'(seen_w.size()), 64'(base + 1));
        chk("t4_word", 64'(seen_w[base]), 64'(32'h74737271));

        // Streaming 64 beats; sixteen more pushes also wrap the 4-bit counter to 1.
        base = seen_w.size();
        send(8'h00, 1'b0);
        s0 = acc_cyc_last;
        for (int i = 1; i < 64; i++) send(8'(i), 1'b0);
        wait_pushes(base + 16);
        step(2);
        chk("t5_pushes", 64'(seen_w.size()), 64'(base + 16));
        chk("t5_cycles", 64'(seen_cyc[base+15] - s0 + 1), 64'(PP ? 65 : 80));
        for (int j = 0; j < 16; j += 5) begin
            w = {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
            chk("t5_word", 64'(seen_w[base+j]), 64'(w));
        end
        chk("t6_wrap", 64'(push_cnt), 64'(1));

        // Random beats, gaps, packet ends and FIFO backpressure.
        rnd_done = 1'b0;
        fork
            begin
                while (!rnd_done) begin
                    bus.wfull = ($urandom_range(0, 3) == 0);
                    @(posedge wclk);
                    #1;
                end
                bus.wfull = 1'b0;
            end
            begin
                for (int i = 0; i < 400; i++) begin
                    send(8'($urandom), ($urandom_range(0, 4) == 0));
                    step($urandom_range(0, 3) == 0 ? 1 : 0);
                end
                rnd_done = 1'b1;
            end
        join
        nb = 0;
        while (busy && nb < 100) begin
            step(1);
            nb++;
        end
        chk("drain_idle", 64'(busy), 64'(0));
        chk("final_cnt", 64'(push_cnt), 64'(model_cnt[CNT_W-1:0]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
